// File: rtl/unary_dot_accumulator_pkg.sv
// Shared types and helpers for the unary dot-product accumulator.
//   state_e           : controller state (IDLE, ACCUM, HOLD), 2 bits.
//   default_acc_width : accumulator width that cannot overflow, given the
//                       per-lane operand width and the number of lanes.
package unary_dot_accumulator_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_e;

  // Each lane contributes at most (2^width-1)^2 < 2^(2*width) pulses. Summing
  // num_in lanes needs clog2(num_in) extra bits.
  function automatic int default_acc_width(input int width, input int num_in);
    return 2 * width + $clog2(num_in);
  endfunction

endpackage

// File: rtl/unary_dot_accumulator_if.sv
// Bundle between the product-block array, the accumulator and the
// writeback stage.
//   start, lane_en       : begin a dot product over the selected lanes
//   unary, lane_done     : per-lane pulse stream and completion pulse
//   busy                 : accumulator is in ACCUM or HOLD
//   sum_valid/sum_ready  : result handshake, sum_data carries the result
// master drives the request side, slave is the accumulator.
interface unary_dot_accumulator_if
  import unary_dot_accumulator_pkg::*;
#(
  parameter int NUM_IN    = 4,
  parameter int WIDTH     = 4,
  parameter int ACC_WIDTH = default_acc_width(WIDTH, NUM_IN)
);

  logic                 start;
  logic [NUM_IN-1:0]    lane_en;
  logic [NUM_IN-1:0]    unary;
  logic [NUM_IN-1:0]    lane_done;
  logic                 busy;
  logic                 sum_valid;
  logic                 sum_ready;
  logic [ACC_WIDTH-1:0] sum_data;

  modport master (
    output start, lane_en, unary, lane_done, sum_ready,
    input  busy, sum_valid, sum_data
  );

  modport slave (
    input  start, lane_en, unary, lane_done, sum_ready,
    output busy, sum_valid, sum_data
  );

endinterface

// File: rtl/unary_dot_accumulator_lane_popcount.sv
// Combinational population count over the per-lane pulse vector.
//   vec   : NUM_IN-bit input vector
//   count : number of set bits, $clog2(NUM_IN+1) bits wide
module unary_dot_accumulator_lane_popcount #(
  parameter  int NUM_IN = 4,
  localparam int CNT_W  = $clog2(NUM_IN + 1)
) (
  input  logic [NUM_IN-1:0] vec,
  output logic [CNT_W-1:0]  count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      count = count + CNT_W'(vec[i]);
    end
  end

endmodule

// File: rtl/unary_dot_accumulator.sv
// Sums the unary pulse streams of NUM_IN product lanes into one binary
// dot-product value and presents it on a valid/ready output once every
// enabled lane has signalled done.
//   clk     : clock, all state updates on posedge
//   reset_n : asynchronous active-low reset
//   bus     : slave side of unary_dot_accumulator_if (request, lane
//             streams, busy, result handshake)
module unary_dot_accumulator
  import unary_dot_accumulator_pkg::*;
#(
  parameter int NUM_IN    = 4,
  parameter int WIDTH     = 4,
  parameter int ACC_WIDTH = default_acc_width(WIDTH, NUM_IN)
) (
  input logic                    clk,
  input logic                    reset_n,
  unary_dot_accumulator_if.slave bus
);

  localparam int CNT_W = $clog2(NUM_IN + 1);

  state_e               state_q, state_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [NUM_IN-1:0]    en_mask_q, en_mask_d;
  logic [NUM_IN-1:0]    done_mask_q, done_mask_d;

  logic [NUM_IN-1:0]    live;
  logic [NUM_IN-1:0]    counted;
  logic [NUM_IN-1:0]    done_next;
  logic [CNT_W-1:0]     pulse_cnt;

  // A lane stops contributing the cycle after its done is registered, so a
  // pulse coinciding with done still counts while later strays do not.
  assign live      = en_mask_q & ~done_mask_q;
  assign counted   = bus.unary & live;
  // Disabled lanes were preloaded as done, so only enabled dones matter.
  assign done_next = done_mask_q | (bus.lane_done & en_mask_q);

  unary_dot_accumulator_lane_popcount #(
    .NUM_IN (NUM_IN)
  ) u_lane_popcount (
    .vec   (counted),
    .count (pulse_cnt)
  );

  always_comb begin
    // NOTE: every *_d gets its hold value first, so no path through the case
    // leaves a signal unassigned and no latch is inferred.
    state_d     = state_q;
    acc_d       = acc_q;
    en_mask_d   = en_mask_q;
    done_mask_d = done_mask_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          acc_d       = '0;
          en_mask_d   = bus.lane_en;
          done_mask_d = ~bus.lane_en;
          state_d     = ACCUM;
        end
      end
      ACCUM: begin
        acc_d       = acc_q + ACC_WIDTH'(pulse_cnt);
        done_mask_d = done_next;
        if (&done_next) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        // start is deliberately ignored here, even alongside the handshake.
        if (bus.sum_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      en_mask_q   <= '0;
      done_mask_q <= '0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values.
      state_q     <= state_d;
      acc_q       <= acc_d;
      en_mask_q   <= en_mask_d;
      done_mask_q <= done_mask_d;
    end
  end

  assign bus.busy      = (state_q != IDLE);
  assign bus.sum_valid = (state_q == HOLD);
  assign bus.sum_data  = acc_q;

endmodule

// File: tb/tb_unary_dot_accumulator.sv
// Self-checking bench for unary_dot_accumulator: table-driven dot products,
// hand-written backpressure and reset sequences, and randomized dot products
// checked against a schedule-level reference model.
module tb_unary_dot_accumulator;

  localparam int NUM_IN    = 4;
  localparam int WIDTH     = 4;
  localparam int ACC_WIDTH = 10;
  localparam int MAXC      = 1024;

  logic clk;
  logic reset_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  unary_dot_accumulator_if #(
    .NUM_IN    (NUM_IN),
    .WIDTH     (WIDTH),
    .ACC_WIDTH (ACC_WIDTH)
  ) bus ();

  unary_dot_accumulator #(
    .NUM_IN    (NUM_IN),
    .WIDTH     (WIDTH),
    .ACC_WIDTH (ACC_WIDTH)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  // One dot product: per lane {lane3, lane2, lane1, lane0} a pulse count,
  // a gap cycle after every `gap` pulses (0 = none), done `dly` cycles after
  // the last pulse, then `stray` pulses after done.
  typedef struct packed {
    logic [3:0]      en;
    logic [3:0][7:0] cnt;
    logic [3:0][3:0] gap;
    logic [3:0][3:0] dly;
    logic [3:0][3:0] stray;
    logic [9:0]      exp_sum;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  logic [NUM_IN-1:0] u_s [MAXC];
  logic [NUM_IN-1:0] d_s [MAXC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Expand a vec_t into per-cycle unary/done vectors.
  task automatic build_sched(input vec_t v, output int t_len);
    t_len = 1;
    for (int c = 0; c < MAXC; c++) begin
      u_s[c] = '0;
      d_s[c] = '0;
    end
    for (int i = 0; i < NUM_IN; i++) begin
      int cyc;
      int d;
      cyc = 0;
      for (int k = 0; k < int'(v.cnt[i]); k++) begin
        u_s[cyc][i] = 1'b1;
        cyc++;
        if (v.gap[i] != 0 && (k + 1) % int'(v.gap[i]) == 0 && k + 1 < int'(v.cnt[i])) cyc++;
      end
      d = ((v.cnt[i] != 0) ? cyc - 1 : 0) + int'(v.dly[i]);
      d_s[d][i] = 1'b1;
      for (int s = 1; s <= int'(v.stray[i]); s++) u_s[d + s][i] = 1'b1;
      if (d + int'(v.stray[i]) + 1 > t_len) t_len = d + int'(v.stray[i]) + 1;
    end
  endtask

  // Reference: an enabled lane contributes every pulse up to and including
  // its first done cycle; the result is ready after the latest such done.
  task automatic model(input logic [3:0] en, output int sum, output int dmax);
    sum  = 0;
    dmax = 0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (en[i]) begin
        int first;
        first = -1;
        for (int c = 0; c < MAXC; c++) if (d_s[c][i] && first < 0) first = c;
        for (int c = 0; c <= first; c++) sum += int'(u_s[c][i]);
        if (first > dmax) dmax = first;
      end
    end
  endtask

  task automatic run_op(input vec_t v, input logic [ACC_WIDTH-1:0] exp_sum,
                        input string name, input bit handshake);
    int t_len;
    int m_sum;
    int dmax;
    build_sched(v, t_len);
    model(v.en, m_sum, dmax);
    @(negedge clk);
    bus.start     = 1'b1;
    bus.lane_en   = v.en;
    bus.unary     = '0;
    bus.lane_done = '0;
    @(negedge clk);
    bus.start = 1'b0;
    check({name, "_busy_after_start"}, 32'(bus.busy), 32'd1);
    check({name, "_valid_after_start"}, 32'(bus.sum_valid), 32'd0);
    for (int c = 0; c < t_len; c++) begin
      bus.unary     = u_s[c];
      bus.lane_done = d_s[c];
      @(negedge clk);
      check({name, "_valid_timing"}, 32'(bus.sum_valid), (c >= dmax) ? 32'd1 : 32'd0);
      check({name, "_busy"}, 32'(bus.busy), 32'd1);
    end
    bus.unary     = '0;
    bus.lane_done = '0;
    check({name, "_sum"}, 32'(bus.sum_data), 32'(exp_sum));
    check({name, "_valid_hold"}, 32'(bus.sum_valid), 32'd1);
    if (handshake) begin
      bus.sum_ready = 1'b1;
      @(negedge clk);
      check({name, "_valid_after_ack"}, 32'(bus.sum_valid), 32'd0);
      check({name, "_busy_after_ack"}, 32'(bus.busy), 32'd0);
      bus.sum_ready = 1'b0;
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t tbl [4];
    vec_t empty_op;
    vec_t rv;
    int   r_sum;
    int   r_dmax;
    int   r_len;

    // single lane: w=3,x=2 as two groups of 3 pulses, disabled lanes noisy
    tbl[0].en      = 4'b0001;
    tbl[0].cnt     = {8'd5, 8'd3, 8'd2, 8'd6};
    tbl[0].gap     = {4'd0, 4'd1, 4'd0, 4'd3};
    tbl[0].dly     = {4'd9, 4'd2, 4'd0, 4'd1};
    tbl[0].stray   = {4'd0, 4'd1, 4'd2, 4'd0};
    tbl[0].exp_sum = 10'd6;
    // full load: 4 x 225
    tbl[1].en      = 4'b1111;
    tbl[1].cnt     = {8'd225, 8'd225, 8'd225, 8'd225};
    tbl[1].gap     = '0;
    tbl[1].dly     = {4'd1, 4'd0, 4'd2, 4'd1};
    tbl[1].stray   = '0;
    tbl[1].exp_sum = 10'd900;
    // mixed finish: 2,0,12,5 with a stray pair on lane0 after its done
    tbl[2].en      = 4'b1111;
    tbl[2].cnt     = {8'd5, 8'd12, 8'd0, 8'd2};
    tbl[2].gap     = {4'd2, 4'd0, 4'd0, 4'd0};
    tbl[2].dly     = {4'd5, 4'd3, 4'd2, 4'd0};
    tbl[2].stray   = {4'd0, 4'd0, 4'd0, 4'd2};
    tbl[2].exp_sum = 10'd19;
    // simultaneous: 4th pulse and done together on every lane
    tbl[3].en      = 4'b1111;
    tbl[3].cnt     = {8'd4, 8'd4, 8'd4, 8'd4};
    tbl[3].gap     = '0;
    tbl[3].dly     = '0;
    tbl[3].stray   = {4'd1, 4'd0, 4'd2, 4'd0};
    tbl[3].exp_sum = 10'd16;

    empty_op.en      = 4'b0000;
    empty_op.cnt     = {8'd3, 8'd1, 8'd0, 8'd2};
    empty_op.gap     = '0;
    empty_op.dly     = {4'd1, 4'd0, 4'd3, 4'd0};
    empty_op.stray   = '0;
    empty_op.exp_sum = 10'd0;

    bus.start     = 1'b0;
    bus.lane_en   = '0;
    bus.unary     = '0;
    bus.lane_done = '0;
    bus.sum_ready = 1'b0;
    reset_n       = 1'b1;
    #1 reset_n = 1'b0;
    #2;
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_valid", 32'(bus.sum_valid), 32'd0);
    check("reset_data", 32'(bus.sum_data), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int t = 0; t < 4; t++) begin
      run_op(tbl[t], tbl[t].exp_sum, $sformatf("tbl%0d", t), 1'b1);
    end

    // backpressure: result must stay put while unary/start/lane_en churn
    run_op(tbl[2], 10'd19, "bp", 1'b0);
    for (int k = 0; k < 5; k++) begin
      bus.unary     = 4'($urandom);
      bus.lane_done = 4'($urandom);
      bus.lane_en   = 4'($urandom);
      bus.start     = (k % 2 == 0);
      @(negedge clk);
      check("bp_valid", 32'(bus.sum_valid), 32'd1);
      check("bp_data", 32'(bus.sum_data), 32'd19);
      check("bp_busy", 32'(bus.busy), 32'd1);
    end
    bus.unary     = '0;
    bus.lane_done = '0;
    bus.sum_ready = 1'b1;
    bus.start     = 1'b1;
    @(negedge clk);
    check("bp_release_valid", 32'(bus.sum_valid), 32'd0);
    check("bp_release_busy", 32'(bus.busy), 32'd0);
    bus.start     = 1'b0;
    bus.sum_ready = 1'b0;
    @(negedge clk);
    check("bp_no_restart", 32'(bus.busy), 32'd0);

    // reset in the middle of ACCUM
    @(negedge clk);
    bus.start   = 1'b1;
    bus.lane_en = 4'hf;
    @(negedge clk);
    bus.start = 1'b0;
    bus.unary = 4'hf;
    repeat (3) @(negedge clk);
    check("rst_pre_data", 32'(bus.sum_data), 32'd12);
    #2 reset_n = 1'b0;
    #1;
    check("rst_mid_busy", 32'(bus.busy), 32'd0);
    check("rst_mid_valid", 32'(bus.sum_valid), 32'd0);
    check("rst_mid_data", 32'(bus.sum_data), 32'd0);
    bus.unary = '0;
    @(negedge clk);
    reset_n = 1'b1;

    // empty lane set: valid two cycles after start with a zero sum
    run_op(empty_op, 10'd0, "empty", 1'b1);

    // randomized dot products against the reference model
    for (int n = 0; n < 30; n++) begin
      rv.en = 4'($urandom);
      for (int i = 0; i < NUM_IN; i++) begin
        rv.cnt[i]   = 8'($urandom_range(0, 40));
        rv.gap[i]   = 4'($urandom_range(0, 3));
        rv.dly[i]   = 4'($urandom_range(0, 5));
        rv.stray[i] = 4'($urandom_range(0, 3));
      end
      build_sched(rv, r_len);
      model(rv.en, r_sum, r_dmax);
      rv.exp_sum = 10'(r_sum);
      run_op(rv, rv.exp_sum, $sformatf("rand%0d", n), 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
